// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional divider hardware is enabled by defining MULDIV_DIV_EN.
package muldiv_pkg;

    localparam int N     = 16;
    localparam int M     = 3;
    localparam int CNT_W = $clog2(N);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        WRITE = 2'b10
    } state_e;

    localparam logic [1:0] OP_MULL = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_REM  = 2'b11;

    localparam logic [N-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_core.sv
// Restoring unsigned divider datapath: one quotient bit per step, MSB first.
// Present only when MULDIV_DIV_EN is defined.
module div_core
    import muldiv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quo_nxt,
    output logic [N-1:0] rem_nxt
);

    logic [N-1:0] rem_q, rem_d;
    logic [N-1:0] quo_q, quo_d;
    logic [N-1:0] dvsr_q, dvsr_d;
    logic [N:0]   part_rem;
    logic [N:0]   trial;

    // Trial subtraction of the divisor from the widened partial remainder
    always_comb begin
        part_rem = {rem_q, quo_q[N-1]};
        trial    = part_rem - {1'b0, dvsr_q};
        quo_nxt  = {quo_q[N-2:0], ~trial[N]};
        rem_nxt  = trial[N] ? part_rem[N-1:0] : trial[N-1:0];
    end

    // Next-state: load operands, take one step, or hold
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvsr_d = dvsr_q;
        if (load) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvsr_d = divisor;
        end else if (step) begin
            rem_d = rem_nxt;
            quo_d = quo_nxt;
        end
    end

    // Divider state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvsr_q <= dvsr_d;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned MUL/DIV unit writing back to the register file.
// Define MULDIV_DIV_EN to include the divider; otherwise ops 10/11 are no-ops.
module mul_div_unit
    import muldiv_pkg::*;
(
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Start,
    input  logic [1:0]   Op,
    input  logic [N-1:0] Operand_a,
    input  logic [N-1:0] Operand_b,
    input  logic [M-1:0] Dest_ad,
    output logic         Busy,
    output logic         Done,
    output logic         Div_by_zero,
    output logic         Reg_Write,
    output logic [M-1:0] Reg_write_ad,
    output logic [N-1:0] Reg_write_data
);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [M-1:0]     dest_q, dest_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [2*N-1:0]   mcand_q, mcand_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic             wr_q, wr_d;
    logic [M-1:0]     wad_q, wad_d;
    logic [N-1:0]     wdata_q, wdata_d;
    logic [2*N-1:0]   acc_step;
    logic [N-1:0]     result;
    logic             accept;

    assign accept = (state_q == IDLE) && Start;

`ifdef MULDIV_DIV_EN
    logic [N-1:0] quo_nxt;
    logic [N-1:0] rem_nxt;

    div_core u_div (
        .clk      (Clock),
        .rst_n    (Reset),
        .load     (accept),
        .step     (state_q == RUN),
        .dividend (Operand_a),
        .divisor  (Operand_b),
        .quo_nxt  (quo_nxt),
        .rem_nxt  (rem_nxt)
    );
`endif

    // Shift-add multiply step and result select for the final iteration
    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        result   = (op_q == OP_MULH) ? acc_step[2*N-1:N]
                                     : acc_step[N-1:0];
`ifdef MULDIV_DIV_EN
        if (op_q == OP_DIV) begin
            result = quo_nxt;
        end else if (op_q == OP_REM) begin
            result = rem_nxt;
        end
`endif
    end

    // Control FSM, operand capture and write-port next state
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dest_d   = dest_q;
        cnt_d    = cnt_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        wr_d     = 1'b0;
        wad_d    = wad_q;
        wdata_d  = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    op_d     = Op;
                    dest_d   = Dest_ad;
                    cnt_d    = '0;
                    mplier_d = Operand_b;
                    mcand_d  = {{N{1'b0}}, Operand_a};
                    acc_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                    if (Op[1]) begin
`ifdef MULDIV_DIV_EN
                        if (Operand_b == '0) begin
                            state_d = WRITE;
                            done_d  = 1'b1;
                            wr_d    = 1'b1;
                            dz_d    = 1'b1;
                            wad_d   = Dest_ad;
                            wdata_d = (Op == OP_DIV) ? DIV0_QUOTIENT
                                                     : Operand_a;
                        end
`else
                        state_d = WRITE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
            RUN: begin
                cnt_d    = cnt_q + 1'b1;
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    state_d = WRITE;
                    done_d  = 1'b1;
                    wr_d    = 1'b1;
                    wad_d   = dest_q;
                    wdata_d = result;
                end
            end
            WRITE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; synchronous active-low reset
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            dest_q   <= '0;
            cnt_q    <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            wr_q     <= 1'b0;
            wad_q    <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dest_q   <= dest_d;
            cnt_q    <= cnt_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            wr_q     <= wr_d;
            wad_q    <= wad_d;
            wdata_q  <= wdata_d;
        end
    end

    assign Busy           = busy_q;
    assign Done           = done_q;
    assign Div_by_zero    = dz_q;
    assign Reg_Write      = wr_q;
    assign Reg_write_ad   = wad_q;
    assign Reg_write_data = wdata_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_mul_div_unit;
    import muldiv_pkg::*;

    logic         Clock;
    logic         Reset;
    logic         Start;
    logic [1:0]   Op;
    logic [N-1:0] Operand_a;
    logic [N-1:0] Operand_b;
    logic [M-1:0] Dest_ad;
    logic         Busy;
    logic         Done;
    logic         Div_by_zero;
    logic         Reg_Write;
    logic [M-1:0] Reg_write_ad;
    logic [N-1:0] Reg_write_data;

    int vectors = 0;
    int errs    = 0;

    logic [N-1:0] last_data;
    logic [M-1:0] last_ad;

    mul_div_unit dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Start          (Start),
        .Op             (Op),
        .Operand_a      (Operand_a),
        .Operand_b      (Operand_b),
        .Dest_ad        (Dest_ad),
        .Busy           (Busy),
        .Done           (Done),
        .Div_by_zero    (Div_by_zero),
        .Reg_Write      (Reg_Write),
        .Reg_write_ad   (Reg_write_ad),
        .Reg_write_data (Reg_write_data)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts one operation (caller sits at a negedge in IDLE) and checks
    // latency, busy span, write-port contents and the return to IDLE.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [M-1:0] d);
        logic [31:0]  prod;
        logic [N-1:0] e_data;
        logic [M-1:0] e_ad;
        logic         e_wr, e_dz;
        int           e_lat, lat;
        logic         busy_ok, o_wr, o_dz, o_busy, o_done;
        logic [N-1:0] o_data;
        logic [M-1:0] o_ad;

        prod   = 32'(a) * 32'(b);
        e_lat  = 17;
        e_wr   = 1'b1;
        e_dz   = 1'b0;
        e_ad   = d;
        e_data = '0;
        case (op)
            OP_MULL: e_data = prod[15:0];
            OP_MULH: e_data = prod[31:16];
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == 0) begin
                    e_lat  = 1;
                    e_dz   = 1'b1;
                    e_data = (op == OP_DIV) ? 16'hFFFF : a;
                end else begin
                    e_data = (op == OP_DIV) ? a / b : a % b;
                end
`else
                e_lat  = 1;
                e_wr   = 1'b0;
                e_data = last_data;
                e_ad   = last_ad;
`endif
            end
        endcase

        Op = op; Operand_a = a; Operand_b = b; Dest_ad = d; Start = 1'b1;
        lat = 0; busy_ok = 1'b1;
        o_wr = 0; o_dz = 0; o_data = '0; o_ad = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clock);
            Start     = 1'b0;
            Op        = 2'($urandom);
            Operand_a = 16'($urandom);
            Operand_b = 16'($urandom);
            Dest_ad   = 3'($urandom);
            if (Busy !== 1'b1) busy_ok = 1'b0;
            if (Done === 1'b1) begin
                lat    = k;
                o_wr   = Reg_Write;
                o_dz   = Div_by_zero;
                o_data = Reg_write_data;
                o_ad   = Reg_write_ad;
                break;
            end
        end
        @(negedge Clock);
        o_busy = Busy;
        o_done = Done;

        chk({tag, "_lat"}, lat, e_lat);
        chk({tag, "_busy"}, busy_ok, 1'b1);
        chk({tag, "_wr"}, o_wr, e_wr);
        chk({tag, "_data"}, o_data, e_data);
        chk({tag, "_ad"}, o_ad, e_ad);
        chk({tag, "_dz"}, o_dz, e_dz);
        chk({tag, "_idle_busy"}, o_busy, 1'b0);
        chk({tag, "_idle_done"}, o_done, 1'b0);
        if (e_wr) begin
            last_data = e_data;
            last_ad   = e_ad;
        end
    endtask

    initial begin
        int  wcount, dcyc;
        logic [N-1:0] wdata;
        logic [M-1:0] wad;
        logic wrote;
        logic [1:0] rop;
        logic [N-1:0] ra, rb;

        Reset = 1'b0; Start = 1'b0; Op = '0;
        Operand_a = '0; Operand_b = '0; Dest_ad = '0;
        last_data = '0; last_ad = '0;
        repeat (3) @(negedge Clock);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_wr", Reg_Write, 1'b0);
        chk("rst_dz", Div_by_zero, 1'b0);
        chk("rst_ad", Reg_write_ad, 3'd0);
        chk("rst_data", Reg_write_data, 16'd0);
        Reset = 1'b1;
        @(negedge Clock);

        run_op("mull7x3", OP_MULL, 16'd7, 16'd3, 3'd2);
        run_op("mulh_ff", OP_MULH, 16'hFFFF, 16'hFFFF, 3'd1);
        run_op("mull_ff", OP_MULL, 16'hFFFF, 16'hFFFF, 3'd3);
        run_op("div100_7", OP_DIV, 16'd100, 16'd7, 3'd4);
        run_op("rem100_7", OP_REM, 16'd100, 16'd7, 3'd5);
        run_op("div5_0", OP_DIV, 16'd5, 16'd0, 3'd6);
        run_op("rem5_0", OP_REM, 16'd5, 16'd0, 3'd7);
        run_op("div_big", OP_DIV, 16'hFFFF, 16'd1, 3'd1);
        run_op("rem_small", OP_REM, 16'd3, 16'hFFFF, 3'd2);

        // Start mid-operation is ignored: exactly one write of 81
        Op = OP_MULL; Operand_a = 16'd9; Operand_b = 16'd9;
        Dest_ad = 3'd5; Start = 1'b1;
        wcount = 0; dcyc = 0; wdata = '0; wad = '0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge Clock);
            Start = (k == 5);
            Operand_a = 16'd3; Operand_b = 16'd3; Dest_ad = 3'd6;
            if (Reg_Write === 1'b1) begin
                wcount++;
                wdata = Reg_write_data;
                wad   = Reg_write_ad;
            end
            if (Done === 1'b1) dcyc = k;
        end
        chk("ign_writes", wcount, 1);
        chk("ign_cycle", dcyc, 17);
        chk("ign_data", wdata, 16'd81);
        chk("ign_ad", wad, 3'd5);
        last_data = 16'd81; last_ad = 3'd5;

        // Reset mid-operation discards the result
        Op = OP_MULL; Operand_a = 16'd11; Operand_b = 16'd13;
        Dest_ad = 3'd7; Start = 1'b1; wrote = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge Clock);
            Start = 1'b0;
            if (Reg_Write === 1'b1) wrote = 1'b1;
            if (k == 8) Reset = 1'b0;
        end
        chk("mrst_busy", Busy, 1'b0);
        chk("mrst_done", Done, 1'b0);
        chk("mrst_wr", wrote, 1'b0);
        Reset = 1'b1;
        last_data = '0; last_ad = '0;
        repeat (20) begin
            @(negedge Clock);
            if (Reg_Write === 1'b1) wrote = 1'b1;
        end
        chk("mrst_nowrite", wrote, 1'b0);

        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom);
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            run_op($sformatf("rnd%0d", i), rop, ra, rb, 3'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative unsigned multiply/divide unit for the 16-bit RISC datapath, one stage downstream of the register file. It captures the two register-file read operands and performs a shift-add multiply or a restoring divide over N cycles. It then writes the result back through the register-file write port (Reg_Write / Reg_write_ad / Reg_write_data). It is shared by the MUL and DIV instruction classes and stalls the control unit through Busy.

## Interface
- N, 16, operand/result width
- M, 3, register address width
- Clock  in  1  single clock; all state changes on posedge
- Reset  in  1  synchronous, active-low; sampled on posedge Clock
- Start  in  1  request; accepted only while Busy=0
- Op  in  2  00 MULL (low half), 01 MULH (high half), 10 DIV (quotient), 11 REM (remainder)
- Operand_a  in  N  multiplicand / dividend (from Reg_read_data_1)
- Operand_b  in  N  multiplier / divisor (from Reg_read_data_2)
- Dest_ad  in  M  destination register address
- Busy  out  1  high from the cycle after an accepted Start through the WRITE cycle
- Done  out  1  one-cycle pulse in the WRITE cycle
- Div_by_zero  out  1  valid with Done; high for DIV/REM with Operand_b=0
- Reg_Write  out  1  register-file write enable; high only in WRITE, subject to the write rules below
- Reg_write_ad  out  M  destination address; holds until the next WRITE
- Reg_write_data  out  N  result; holds until the next WRITE

## Operation
- FSM states: IDLE, RUN, WRITE. Reset forces IDLE.
- IDLE with Start=1:
  - Capture Op, Operand_a, Operand_b and Dest_ad.
  - Clear the iteration counter.
  - Go to RUN.
  - Exception: DIV/REM with Operand_b=0 goes directly to WRITE.
- RUN: one iteration per cycle. The counter runs 0..N-1; on N-1, go to WRITE.
- WRITE:
  - Reg_Write=1 and Done=1.
  - Reg_write_ad is the captured Dest_ad; Reg_write_data is the selected result.
  - Next state is IDLE.
- Multiply (unsigned):
  - 2N-bit accumulator; each iteration adds the shifted multiplicand when the current multiplier bit is 1.
  - MULL returns product[N-1:0]; MULH returns product[2N-1:N].
- Divide (unsigned, restoring):
  - (N+1)-bit partial remainder; one quotient bit per iteration, MSB first.
  - DIV returns the quotient; REM returns the remainder.
- Divide by zero: quotient = all ones (16'hFFFF), remainder = Operand_a, Div_by_zero=1.
- Start while Busy=1 (including the WRITE cycle) is ignored; no queueing.
- Operand inputs may change freely after the Start cycle.
- Reset low in any state:
  - Next state is IDLE.
  - Busy, Done, Reg_Write and Div_by_zero are 0.
  - An in-flight operation is discarded and no write occurs.

## Timing
- Reset values: Busy=0, Done=0, Reg_Write=0, Div_by_zero=0, Reg_write_ad=0, Reg_write_data=0. All outputs are registered.
- Start sampled at edge 0: RUN covers cycles 1..N, WRITE is cycle N+1 (17 for N=16), and IDLE is back at N+2.
- Divide-by-zero: WRITE in cycle 1.
- Earliest back-to-back Start is sampled in cycle N+2.
- Register-file write-then-read hazards are the control unit's responsibility; this block has no forwarding path.

## Configuration
- MULDIV_DIV_EN defined: ops 10/11 perform division as specified.
- MULDIV_DIV_EN undefined:
  - Divider hardware is removed.
  - Ops 10/11 go IDLE→WRITE in one cycle with Done=1, Reg_Write=0 (no register modified), Div_by_zero=0 and Reg_write_data unchanged.

## Structure
- Package muldiv_pkg holds:
  - the state enum (IDLE/RUN/WRITE);
  - Op encodings (OP_MULL, OP_MULH, OP_DIV, OP_REM);
  - the DIV0_QUOTIENT constant (all ones).
- Sub-module div_core holds the restoring-divide iteration (partial remainder, quotient shift). It is instantiated only under MULDIV_DIV_EN.
- Multiply, FSM and write port stay in the top module.

## Test plan
- MULL 7×3, Dest_ad=2, Start at cycle 0 -> Busy high cycles 1-17; cycle 17: Reg_Write=1, Reg_write_ad=2, Reg_write_data=21, Done=1.
- 16'hFFFF×16'hFFFF -> MULH data 16'hFFFE, MULL data 16'h0001, Div_by_zero=0.
- DIV 100/7 -> 14; REM 100/7 -> 2; each with WRITE in cycle 17.
- DIV 5/0 -> cycle 1: Reg_Write=1, data 16'hFFFF, Div_by_zero=1; REM 5/0 -> data 5, Div_by_zero=1.
- MULL 9×9 started; Start with new operands at cycle 5 is ignored (81 written in cycle 17, one write only). Then MULL started again, with Reset low at cycle 8 -> no Reg_Write; Busy=0 at cycle 9.
- With MULDIV_DIV_EN undefined, Op=10 -> Done=1 in cycle 1, Reg_Write=0, Reg_write_data unchanged from the previous result.
